nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit built on a single 4-bit ripple adder slice.
//  - Processes one nibble per clock, LSB first, with a registered carry between nibbles.
//  - Sequences operand loading, nibble selection, carry chaining and result assembly.
//  - Sits between a register-file/bus master (start/ready/done handshake) and the shared
//    4-bit adder datapath, trading latency for area.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4, >= 8
//  NIBBLES  WIDTH/4   derived localparam, not overridable; number of RUN cycles
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; accepted only when ready=1
//  sub       in   1      0: a+b, 1: a-b (sampled with start)
//  a         in   WIDTH  operand A (sampled with start)
//  b         in   WIDTH  operand B (sampled with start)
//  ready     out  1      1 in IDLE and DONE states
//  busy      out  1      1 in RUN state
//  done      out  1      one-cycle pulse: result valid
//  sum       out  WIDTH  result; held from done until next accepted start
//  cout      out  1      final carry (add: carry out; sub: 1 = no borrow)
//  ovf       out  1      signed overflow of the full WIDTH-bit result
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; ready=1, busy=0, done=0, sum=0, cout=0, ovf=0;
//    nibble index, carry and operand registers cleared. rst overrides every other input.
//  - FSM IDLE -> RUN on start&ready; RUN -> DONE after nibble NIBBLES-1; DONE -> IDLE,
//    or DONE -> RUN when start is high in DONE (back-to-back accepted, no bubble).
//  - Accept: latch a into opA, (sub ? ~b : b) into opB, carry <= sub, idx <= 0.
//  - RUN cycle i (i = 0..NIBBLES-1): slice adds opA[4i+3:4i] + opB[4i+3:4i] + carry;
//    sum nibble i <= slice sum, carry <= slice cout, idx <= idx+1.
//  - On nibble NIBBLES-1: cout <= slice cout; ovf <= (opA msb == opB msb) &&
//    (result msb != opA msb). State goes to DONE.
//  - Latency: start high in cycle 0 -> busy in cycles 1..NIBBLES -> done=1 in cycle
//    NIBBLES+1 (cycle 5 for WIDTH=16). Throughput: one op per NIBBLES+1 cycles.
//  - start while busy=1: ignored, no effect on operands or result; not queued.
//  - a, b, sub changing during RUN: no effect (operands registered at accept).
//  - sum/cout/ovf are stable and valid from the done cycle until the next accept;
//    partial nibbles of a new op may overwrite sum during RUN (not valid while busy).
//  - Carry wraps out of the top nibble only into cout; no carry into the next op.
//  - rst during RUN: op aborted, no done pulse, outputs go to reset values next cycle.
//  - idx never exceeds NIBBLES-1; unused encodings of the state register go to IDLE.
// STRUCTURE
//  - Package nibble_serial_adder_pkg: NIB_W = 4 constant; state enum
//    {S_IDLE, S_RUN, S_DONE} (2-bit); helper function clog2 for idx width.
//  - Sub-module nibble_add4: combinational 4-bit adder, ports a[3:0], b[3:0], cin,
//    sum[3:0], cout; built from four 1-bit full-adder cells; one instance in this block.
//  - Top: FSM, idx counter, carry flop, operand registers, nibble mux, result registers.
// TESTING (WIDTH=16 unless noted)
//  - Add 0x1234 + 0x4321, sub=0 -> done in cycle 5, sum=0x5555, cout=0, ovf=0.
//  - Full ripple: 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 ->
//    sum=0x8000, cout=0, ovf=1.
//  - Subtract 0x0005 - 0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0;
//    0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//  - start pulsed in cycles 2 and 3 of a running op with new a/b -> ignored; result
//    equals first operands, exactly one done pulse.
//  - rst asserted in cycle 2 of an op -> no done, next cycle ready=1, sum=0; a new op
//    then completes correctly.
//  - Back-to-back: start held high through DONE -> second op accepted in the done
//    cycle, second done 5 cycles later; repeat with WIDTH=8 (done in cycle 3).

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared nibble width, FSM state encoding and an index-width helper.
package nibble_serial_adder_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  // Minimum bits needed to count v values; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit ripple adder built from four full-adder cells.
//   a, b : nibble operands   cin : carry in
//   sum  : nibble result     cout : carry out of bit 3
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);
  logic [NIB_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract, one nibble per clock through a single 4-bit slice.
//   clk, rst     : clock, synchronous active-high reset
//   start/ready  : request handshake; operands a, b and mode sub sampled on start&ready
//   busy         : nibbles being processed     done : one-cycle result-valid pulse
//   sum/cout/ovf : result, final carry (sub: 1 = no borrow), signed overflow
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W = clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0] idx_q;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c, accept, last;
  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy   = state_q == S_RUN;
  assign done   = state_q == S_DONE;
  assign accept = start & ready;
  assign last   = idx_q == LAST;
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  nibble_add4 u_add (
    .a   (opa_q[idx_q*NIB_W +: NIB_W]),
    .b   (opb_q[idx_q*NIB_W +: NIB_W]),
    .cin (carry_q),
    .sum (nib_s),
    .cout(nib_c)
  );
  // Starting from DONE goes straight back to RUN so back-to-back ops have no bubble.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last ? S_DONE : S_RUN;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q   <= a;
        opb_q   <= sub ? ~b : b;
        carry_q <= sub;
        idx_q   <= '0;
      end else if (busy) begin
        sum_q[idx_q*NIB_W +: NIB_W] <= nib_s;
        carry_q <= nib_c;
        idx_q   <= last ? '0 : idx_q + IDX_W'(1);
        if (last) begin
          cout_q <= nib_c;
          ovf_q  <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (nib_s[NIB_W-1] != opa_q[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for 16-bit and 8-bit instances against an arithmetic model.
module tb_nibble_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic ready, busy, done, cout, ovf;
  logic [15:0] sum;
  logic start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  int cyc = 0, nchk = 0, nerr = 0;
  typedef struct {logic [15:0] sum; logic cout; logic ovf; int cyc;} exp_t;
  exp_t q16[$], q8[$];
  exp_t last16;
  logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));
  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned result modulo 2^w, carry/no-borrow, signed range test.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input int c);
    longint m, h, ux, uy, sx, sy, r, sr;
    exp_t e;
    m  = longint'(1) << w;
    h  = m >> 1;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= h) ? ux - m : ux;
    sy = (uy >= h) ? uy - m : uy;
    r  = s ? ux - uy : ux + uy;
    sr = s ? sx - sy : sx + sy;
    e.sum  = 16'(r & (m - 1));
    e.cout = s ? (ux >= uy) : (r >= m);
    e.ovf  = (sr < -h) || (sr >= h);
    e.cyc  = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) last16 = '{default: 0};
    else if (done) begin
      if (q16.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL done16_unexpected: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        e = q16.pop_front();
        check("sum16", sum, e.sum);
        check("cout16", cout, e.cout);
        check("ovf16", ovf, e.ovf);
        check("done16_cycle", cyc, e.cyc);
        check("busy16_in_done", busy, 0);
        last16 = e;
      end
    end else if (ready) begin
      check("hold_sum16", sum, last16.sum);
      check("hold_cout16", cout, last16.cout);
      check("hold_ovf16", ovf, last16.ovf);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL done8_unexpected: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        e = q8.pop_front();
        check("sum8", sum8, e.sum);
        check("cout8", cout8, e.cout);
        check("ovf8", ovf8, e.ovf);
        check("done8_cycle", cyc, e.cyc);
      end
    end
  end

  // Called away from the clock edge; start is sampled at the following posedge.
  task automatic issue(input bit w8, input logic [15:0] x, input logic [15:0] y, input logic s);
    if (w8) begin
      check("ready8_at_issue", ready8, 1);
      a8 = x[7:0]; b8 = y[7:0]; sub8 = s; start8 = 1'b1;
      q8.push_back(model(8, {8'h00, x[7:0]}, {8'h00, y[7:0]}, s, cyc + 3));
    end else begin
      check("ready16_at_issue", ready, 1);
      a = x; b = y; sub = s; start = 1'b1;
      q16.push_back(model(16, x, y, s, cyc + 5));
    end
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic wait_done(input bit w8);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w8 ? done8 : done) && n < 20);
    if (!(w8 ? done8 : done)) begin
      nchk++; nerr++;
      $display("FAIL timeout_done%0d: got no done expected one within 20 cycles", w8 ? 8 : 16);
    end
  endtask

  task automatic op(input bit w8, input logic [15:0] x, input logic [15:0] y, input logic s);
    issue(w8, x, y, s);
    wait_done(w8);
  endtask

  // Start held high through RUN and DONE: the second op is accepted in the done cycle.
  task automatic back_to_back(input bit w8, input int lat);
    int n0;
    logic [15:0] x, y;
    n0 = cyc;
    x = 16'($urandom); y = 16'($urandom);
    if (w8) begin
      a8 = x[7:0]; b8 = y[7:0]; sub8 = 1'b0; start8 = 1'b1;
      q8.push_back(model(8, {8'h00, x[7:0]}, {8'h00, y[7:0]}, 1'b0, n0 + lat));
    end else begin
      a = x; b = y; sub = 1'b0; start = 1'b1;
      q16.push_back(model(16, x, y, 1'b0, n0 + lat));
    end
    @(posedge clk); #1;
    x = 16'($urandom); y = 16'($urandom);
    if (w8) begin
      a8 = x[7:0]; b8 = y[7:0]; sub8 = 1'b1;
      q8.push_back(model(8, {8'h00, x[7:0]}, {8'h00, y[7:0]}, 1'b1, n0 + 2 * lat));
    end else begin
      a = x; b = y; sub = 1'b1;
      q16.push_back(model(16, x, y, 1'b1, n0 + 2 * lat));
    end
    wait_done(w8);
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0;
    wait_done(w8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x, y;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready8", ready8, 1);
    check("rst_sum8", sum8, 0);
    @(negedge clk);
    op(0, 16'h1234, 16'h4321, 1'b0);
    op(0, 16'hFFFF, 16'h0001, 1'b0);
    op(0, 16'h7FFF, 16'h0001, 1'b0);
    op(0, 16'h0005, 16'h0007, 1'b1);
    op(0, 16'h8000, 16'h0001, 1'b1);
    // start pulses with new operands while busy must be ignored
    issue(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1;
    @(posedge clk); #1;
    a = 16'hCAFE; b = 16'hF00D;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);
    repeat (6) @(negedge clk);
    // reset in the middle of an op aborts it
    issue(0, 16'hABCD, 16'h1357, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    q16.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    repeat (8) @(negedge clk);
    op(0, 16'h0F0F, 16'h00F1, 1'b0);
    @(negedge clk);
    back_to_back(0, 5);
    @(negedge clk);
    back_to_back(1, 3);
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      x = 16'($urandom); y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) y = corners[$urandom_range(0, 3)];
      op(0, x, y, 1'($urandom));
    end
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op(1, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    repeat (6) @(negedge clk);
    check("q16_drained", q16.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
